// File: rtl/fpu_div.sv
// fpu_div: iterative single-precision divider (OP1 / OP2), one restoring
// division step per clock. The quotient is truncated. Exponent overflow and
// underflow wrap silently. Denormal inputs are treated as normal numbers.
//
// Optional build macro FPU_DIV_SPECIAL_EN enables special-operand handling
// (zero, infinity, NaN), which produces its result one cycle after the start.
// Without the macro, every operand takes the full 26-cycle arithmetic path.
module fpu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] OP1,
    input  logic [31:0] OP2,
    input  logic        div_select,
    output logic [31:0] Result,
    output logic        valid,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    localparam logic [4:0] LAST_STEP = 5'd24;

    logic [1:0]  r_state;
    logic        r_sign;
    // Only the low byte of the biased exponent reaches the result. Overflow
    // wraps, so 8-bit arithmetic gives the same bits as a wider signed sum.
    logic [7:0]  r_exp;
    logic [25:0] r_rem;
    logic [23:0] r_div;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_valid;
    logic        r_busy;

    logic        w_sign;
    logic [7:0]  w_exp_start;
    logic        w_ge;
    logic [25:0] w_rem_sub;
    logic [25:0] w_rem_next;
    logic [24:0] w_q_next;
    logic [7:0]  w_norm_exp;
    logic [22:0] w_norm_frac;

    assign w_sign      = OP1[31] ^ OP2[31];
    assign w_exp_start = OP1[30:23] - OP2[30:23] + 8'd127;

    // One restoring step: subtract the divisor when it fits, then shift.
    assign w_ge        = (r_rem >= {2'b00, r_div});
    assign w_rem_sub   = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;
    assign w_rem_next  = w_rem_sub << 1;
    assign w_q_next    = {r_q[23:0], w_ge};

    // The mantissa ratio lies in (0.5, 2), so the quotient leads with either
    // q[24] or q[23]. The second case needs one more place of normalisation.
    assign w_norm_exp  = r_q[24] ? r_exp : (r_exp - 8'd1);
    assign w_norm_frac = r_q[24] ? r_q[23:1] : r_q[22:0];

`ifdef FPU_DIV_SPECIAL_EN
    logic        r_special;
    logic [31:0] r_spec_res;

    logic        w_max1;
    logic        w_max2;
    logic        w_nan1;
    logic        w_nan2;
    logic        w_inf1;
    logic        w_inf2;
    logic        w_zero1;
    logic        w_zero2;
    logic        w_special;
    logic [31:0] w_spec_res;

    assign w_max1    = (OP1[30:23] == 8'hFF);
    assign w_max2    = (OP2[30:23] == 8'hFF);
    assign w_nan1    = w_max1 & (|OP1[22:0]);
    assign w_nan2    = w_max2 & (|OP2[22:0]);
    assign w_inf1    = w_max1 & ~(|OP1[22:0]);
    assign w_inf2    = w_max2 & ~(|OP2[22:0]);
    assign w_zero1   = ~(|OP1[30:0]);
    assign w_zero2   = ~(|OP2[30:0]);
    assign w_special = w_max1 | w_max2 | w_zero1 | w_zero2;

    // Select the fixed result for special operands; indeterminate forms first.
    always_comb begin
        w_spec_res = 32'h0000_0000;
        if (w_nan1 | w_nan2 | (w_zero1 & w_zero2) | (w_inf1 & w_inf2)) begin
            w_spec_res = 32'h7FC0_0000;
        end else if (w_zero2 | w_inf1) begin
            w_spec_res = {w_sign, 31'h7F80_0000};
        end else begin
            w_spec_res = {w_sign, 31'h0000_0000};
        end
    end
`endif

    // Control FSM and datapath registers: start capture, division steps, normalise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sign     <= 1'b0;
            r_exp      <= 8'd0;
            r_rem      <= 26'd0;
            r_div      <= 24'd0;
            r_q        <= 25'd0;
            r_cnt      <= 5'd0;
            r_result   <= 32'h0000_0000;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
`ifdef FPU_DIV_SPECIAL_EN
            r_special  <= 1'b0;
            r_spec_res <= 32'h0000_0000;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (div_select) begin
                        r_sign <= w_sign;
                        r_exp  <= w_exp_start;
                        r_rem  <= {2'b00, 1'b1, OP1[22:0]};
                        r_div  <= {1'b1, OP2[22:0]};
                        r_q    <= 25'd0;
                        r_cnt  <= 5'd0;
                        r_busy <= 1'b1;
`ifdef FPU_DIV_SPECIAL_EN
                        if (w_special) begin
                            r_special  <= 1'b1;
                            r_spec_res <= w_spec_res;
                            r_state    <= S_NORM;
                        end else begin
                            r_special  <= 1'b0;
                            r_state    <= S_DIV;
                        end
`else
                        r_state <= S_DIV;
`endif
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
`ifdef FPU_DIV_SPECIAL_EN
                    if (r_special) begin
                        r_result <= r_spec_res;
                    end else begin
                        r_result <= {r_sign, w_norm_exp, w_norm_frac};
                    end
`else
                    r_result <= {r_sign, w_norm_exp, w_norm_frac};
`endif
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Result = r_result;
    assign valid  = r_valid;
    assign busy   = r_busy;

endmodule

// File: tb/tb_fpu_div.sv
// tb_fpu_div: self-checking bench for fpu_div. Expected quotients come from an
// integer long-division reference model. Special-operand cases are exercised
// when FPU_DIV_SPECIAL_EN is defined.
module tb_fpu_div;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic        div_select;
    logic [31:0] Result;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam int LAT_FULL = 26;

    fpu_div dut (
        .clk        (clk),
        .rst        (rst),
        .OP1        (OP1),
        .OP2        (OP2),
        .div_select (div_select),
        .Result     (Result),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference quotient: exact integer division of the mantissas, truncated.
    function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
        longint unsigned n;
        longint unsigned d;
        longint unsigned q;
        int              e;
        logic [22:0]     frac;
        n = 64'h80_0000 | 64'(a[22:0]);
        d = 64'h80_0000 | 64'(b[22:0]);
        q = (n << 24) / d;
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= 64'h100_0000) begin
            frac = q[23:1];
        end else begin
            frac = q[22:0];
            e    = e - 1;
        end
        return {a[31] ^ b[31], e[7:0], frac};
    endfunction

    function automatic bit ref_is_special(input logic [31:0] a, input logic [31:0] b);
`ifdef FPU_DIV_SPECIAL_EN
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
               (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_special(input logic [31:0] a, input logic [31:0] b);
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic s;
        s      = a[31] ^ b[31];
        nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        zero_a = (a[30:0] == 31'd0);
        zero_b = (b[30:0] == 31'd0);
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) return 32'h7FC0_0000;
        if (zero_b || inf_a) return {s, 31'h7F80_0000};
        return {s, 31'h0};
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b);
        if (ref_is_special(a, b)) return ref_special(a, b);
        return ref_quot(a, b);
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
        if (ref_is_special(a, b)) return 1;
        return LAT_FULL;
    endfunction

    // Drives one start and waits (bounded) for valid; reports what it observed.
    // Optionally pulses div_select with other operands at cycle inject_at.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output logic [31:0] res,
                          output int busy_low, output logic busy_end);
        OP1 = a;
        OP2 = b;
        div_select = 1'b1;
        @(posedge clk); #1;
        div_select = 1'b0;
        OP1 = $urandom;
        OP2 = $urandom;
        lat = 0;
        busy_low = 0;
        while (valid !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            if (lat == inject_at) begin
                OP1 = ia;
                OP2 = ib;
                div_select = 1'b1;
            end else begin
                div_select = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        div_select = 1'b0;
        res = Result;
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        div_select = 1'b0;
        OP1 = 32'h40C0_0000;
        OP2 = 32'h4000_0000;
        repeat (2) @(posedge clk);
        #1;
        div_select = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        div_select = 1'b0;
        checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want %h", Result, 32'h0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins_start: busy %b want 0", busy); end
    endtask

    task automatic test_directed();
        int lat, bl;
        logic [31:0] res;
        logic be;
        logic [31:0] ta[3];
        logic [31:0] tb[3];
        logic [31:0] te[3];
        ta[0] = 32'h40C0_0000; tb[0] = 32'h4000_0000; te[0] = 32'h4040_0000;
        ta[1] = 32'h3F80_0000; tb[1] = 32'h4040_0000; te[1] = 32'h3EAA_AAAA;
        ta[2] = 32'h3F80_0000; tb[2] = 32'h0000_0000;
`ifdef FPU_DIV_SPECIAL_EN
        te[2] = 32'h7F80_0000;
`else
        te[2] = 32'h7F00_0000;
`endif
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], -1, 32'h0, 32'h0, lat, res, bl, be);
            checks++; if (res !== te[i]) begin errors++; $display("FAIL directed%0d_result: got %h want %h", i, res, te[i]); end
            checks++; if (lat != ref_latency(ta[i], tb[i])) begin errors++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, ref_latency(ta[i], tb[i])); end
            checks++; if (bl != 0) begin errors++; $display("FAIL directed%0d_busy: busy low %0d cycles want 0", i, bl); end
            checks++; if (be !== 1'b0) begin errors++; $display("FAIL directed%0d_busy_end: got %b want 0", i, be); end
            @(posedge clk); #1;
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL directed%0d_valid_pulse: got %b want 0", i, valid); end
            checks++; if (Result !== te[i]) begin errors++; $display("FAIL directed%0d_hold: got %h want %h", i, Result, te[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bl;
        logic [31:0] res;
        logic be;
        run_op(32'hC0F0_0000, 32'h4020_0000, -1, 32'h0, 32'h0, lat, res, bl, be);
        checks++; if (res !== 32'hC040_0000) begin errors++; $display("FAIL b2b_first: got %h want %h", res, 32'hC040_0000); end
        run_op(32'h40C0_0000, 32'h4000_0000, -1, 32'h0, 32'h0, lat, res, bl, be);
        checks++; if (res !== 32'h4040_0000) begin errors++; $display("FAIL b2b_second: got %h want %h", res, 32'h4040_0000); end
        checks++; if (lat != LAT_FULL) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT_FULL); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        int lat, bl, extra;
        logic [31:0] res;
        logic be;
        run_op(32'h40C0_0000, 32'h4000_0000, 5, 32'h3F80_0000, 32'h4040_0000, lat, res, bl, be);
        checks++; if (res !== 32'h4040_0000) begin errors++; $display("FAIL ignored_result: got %h want %h", res, 32'h4040_0000); end
        checks++; if (lat != LAT_FULL) begin errors++; $display("FAIL ignored_latency: got %0d want %0d", lat, LAT_FULL); end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ignored_extra_valid: got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        OP1 = 32'h3F80_0000;
        OP2 = 32'h4040_0000;
        div_select = 1'b1;
        @(posedge clk); #1;
        div_select = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
        checks++; if (Result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want %h", Result, 32'h0); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_valid: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_random();
        int lat, bl, gap;
        logic [31:0] res, a, b, exp_res;
        logic be;
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            b = $urandom;
`ifdef FPU_DIV_SPECIAL_EN
            case ($urandom_range(0, 7))
                0: a[30:0] = 31'd0;
                1: b[30:0] = 31'd0;
                2: a[30:0] = 31'h7F80_0000;
                3: b[30:23] = 8'hFF;
                default: begin
                    if (a[30:23] == 8'hFF) a[30] = 1'b0;
                    if (b[30:23] == 8'hFF) b[30] = 1'b0;
                end
            endcase
`endif
            exp_res = ref_result(a, b);
            run_op(a, b, -1, 32'h0, 32'h0, lat, res, bl, be);
            checks++; if (res !== exp_res) begin errors++; $display("FAIL random%0d_result: %h/%h got %h want %h", n, a, b, res, exp_res); end
            checks++; if (lat != ref_latency(a, b)) begin errors++; $display("FAIL random%0d_latency: got %0d want %0d", n, lat, ref_latency(a, b)); end
            checks++; if (bl != 0) begin errors++; $display("FAIL random%0d_busy: busy low %0d cycles want 0", n, bl); end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        div_select = 1'b0;
        OP1 = 32'h0;
        OP2 = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
